// File: rtl/spd_pll_sequencer.sv
// SPD-domain PLL sequencer: drives PLL reset, supervises lock with retry on timeout, and issues a debounced ready.
// Optional macro SPD_PLL_AUTO_RELOCK_EN: lock loss in RUN restarts the full sequence instead of faulting.
module spd_pll_sequencer #(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int STABLE_CYCLES       = 64,
  parameter int MAX_RETRIES         = 3,
  localparam int RW = ($clog2(MAX_RETRIES + 1) < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_pll_locked,
  input  logic          i_restart,
  output logic          o_pll_reset,
  output logic          o_ready,
  output logic          o_fault,
  output logic [RW-1:0] o_retry_count,
  output logic [2:0]    o_state
);

  localparam int MAX_A  = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAXCYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW     = ($clog2(MAXCYC) < 1) ? 1 : $clog2(MAXCYC);

  localparam logic [2:0] S_RESET_HOLD = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] S_STABLE     = 3'd2;
  localparam logic [2:0] S_RUN        = 3'd3;
  localparam logic [2:0] S_FAULT      = 3'd4;

  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          sync1_q, lk_q;
  logic          pll_reset_q, ready_q, fault_q;

  // PLL LOCKED is asynchronous to i_clk
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      sync1_q <= i_pll_locked;
      lk_q    <= sync1_q;
    end
  end

  // Counter defaults to zero so every transition (and the idle RUN/FAULT states) clears it
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    retry_d = retry_q;
    if (i_restart) begin
      state_d = S_RESET_HOLD;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET_HOLD: begin
          if (cnt_q == HOLD_LAST) state_d = S_WAIT_LOCK;
          else                    cnt_d   = cnt_q + CW'(1);
        end
        S_WAIT_LOCK: begin
          if (lk_q) begin
            state_d = S_STABLE;
          end else if (cnt_q == TO_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + RW'(1);
              state_d = S_RESET_HOLD;
            end else begin
              state_d = S_FAULT;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_STABLE: begin
          if (!lk_q)                  state_d = S_WAIT_LOCK;
          else if (cnt_q == STB_LAST) state_d = S_RUN;
          else                        cnt_d   = cnt_q + CW'(1);
        end
        S_RUN: begin
          if (!lk_q) begin
`ifdef SPD_PLL_AUTO_RELOCK_EN
            state_d = S_RESET_HOLD;
            retry_d = '0;
`else
            state_d = S_FAULT;
`endif
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_RESET_HOLD;
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as o_state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_RESET_HOLD;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= (state_d == S_RESET_HOLD) || (state_d == S_FAULT);
      ready_q     <= (state_d == S_RUN);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign o_pll_reset   = pll_reset_q;
  assign o_ready       = ready_q;
  assign o_fault       = fault_q;
  assign o_retry_count = retry_q;
  assign o_state       = state_q;

endmodule
